// File: rtl/regfile_pkg.sv
// Shared constants for the core register file: bus widths, register count, control encodings.
package regfile_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int RegNum     = 32;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic RstEnable   = 1'b0;
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, r0 hardwired to zero; two combinational read ports, one synchronous write port.
// Optional REGFILE_BYPASS_EN forwards a same-cycle write to a matching read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we == WriteEnable && waddr != '0) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Priority: reset, disabled port, r0, forwarded write, stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              rst_v,
    input logic              re_v,
    input logic [ADDR_W-1:0] raddr_v,
`ifdef REGFILE_BYPASS_EN
    input logic              we_v,
    input logic [ADDR_W-1:0] waddr_v,
    input logic [DATA_W-1:0] wdata_v,
`endif
    input logic [DATA_W-1:0] mem_v
  );
    logic [DATA_W-1:0] res;
    res = mem_v;
    if (rst_v == RstEnable) begin
      res = '0;
    end else if (re_v != ReadEnable) begin
      res = '0;
    end else if (raddr_v == '0) begin
      res = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we_v == WriteEnable && waddr_v == raddr_v) begin
      res = wdata_v;
`endif
    end
    return res;
  endfunction

  always_comb begin
    rdata1 = read_port(rst, re1, raddr1,
`ifdef REGFILE_BYPASS_EN
                       we, waddr, wdata,
`endif
                       mem_q[raddr1]);
  end

  always_comb begin
    rdata2 = read_port(rst, re2, raddr2,
`ifdef REGFILE_BYPASS_EN
                       we, waddr, wdata,
`endif
                       mem_q[raddr2]);
  end

endmodule

// File: tb/tb_regfile.sv
// Directed, table-driven bench for regfile; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;

  int errors = 0;
  int checks = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  initial begin
    logic [31:0] e;

    // Vectors: each row is one cycle; reads are checked before the row's write edge.
    vecs[0]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 5'd3,  1'b0, 5'd3,  32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  1'b0, 5'd3,  32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd7,  32'hA5A5_A5A5, 1'b1, 5'd3,  1'b1, 5'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd7,  1'b0, 5'd7,  32'hA5A5_A5A5, 32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd31, 32'hA5A5_A5A5, 32'h0000_0001};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd31, 1'b1, 5'd7,  32'h0000_0001, 32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 5'd9,  32'h1111_1111, 1'b0, 5'd9,  1'b1, 5'd31, 32'h0, 32'h0000_0001};
    vecs[9]  = '{1'b1, 5'd9,  32'h2222_2222, 1'b1, 5'd9,  1'b0, 5'd9,
                 BYP ? 32'h2222_2222 : 32'h1111_1111, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b1, 5'd9,  32'h2222_2222, 32'h2222_2222};
    vecs[11] = '{1'b1, 5'd9,  32'h3333_3333, 1'b1, 5'd5,  1'b1, 5'd9,
                 32'h0, BYP ? 32'h3333_3333 : 32'h2222_2222};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  1'b0, 5'd9,  32'h3333_3333, 32'h0};

    // Reset state: outputs forced low while reset is held.
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
    #2;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Preload r5, then assert reset asynchronously mid-cycle.
    drive(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    check("preload_r5_p1", rdata1, 32'h1234_5678);
    check("preload_r5_p2", rdata2, 32'h1234_5678);
    #1 rst = 1'b0;
    #1;
    check("async_rst_p1", rdata1, 32'h0);
    check("async_rst_p2", rdata2, 32'h0);
    drive(1'b1, 5'd6, 32'hCAFE_F00D, 1'b1, 5'd6, 1'b1, 5'd6);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd6);
    #1;
    check("post_rst_r5", rdata1, 32'h0);
    check("write_in_rst_r6", rdata2, 32'h0);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].re1, vecs[i].raddr1, vecs[i].re2, vecs[i].raddr2);
      #1;
      check($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp1);
      check($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].exp2);
    end

    // Sweep: fill r1..r31, then read back on both ports in opposite orders.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0, 1'b0, 5'd0);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      #1;
      e = 32'(i) * 32'h0101_0101;
      check($sformatf("sweep_p1_r%0d", i), rdata1, e);
      e = 32'(31 - i) * 32'h0101_0101;
      check($sformatf("sweep_p2_r%0d", 31 - i), rdata2, e);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
